// File: rtl/simple_fifo_arb_pkg.sv
// Shared types and helpers for the simple_fifo write-port arbiter.
// Holds the FSM encoding and the one-hot grant encoder.
package simple_fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   localparam int MAX_REQ = 8;

   function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
      logic [MAX_REQ-1:0] v_oh;
      v_oh      = '0;
      v_oh[idx] = 1'b1;
      return v_oh;
   endfunction

endpackage

// File: rtl/simple_fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_rr_ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_rr_ptr,
   output logic [IDX_W-1:0]   o_pick,
   output logic               o_valid
);

   always_comb begin
      logic [IDX_W:0]   v_sum;
      logic [IDX_W-1:0] v_idx;
      o_pick  = '0;
      o_valid = 1'b0;
      v_sum   = '0;
      v_idx   = '0;
      // Scan farthest-first so the nearest set bit is the last one written.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         v_sum = {1'b0, i_rr_ptr} + (IDX_W + 1)'(k);
         if (v_sum >= (IDX_W + 1)'(NUM_REQ)) begin
            v_sum = v_sum - (IDX_W + 1)'(NUM_REQ);
         end
         v_idx = v_sum[IDX_W-1:0];
         if (i_req[v_idx]) begin
            o_pick  = v_idx;
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/simple_fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters,
// with bounded bursts and flow control that counts the write already in flight.
module simple_fifo_write_arbiter
   import simple_fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] data,
   output logic [NUM_REQ-1:0]       ack,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     fifo_we,
   output logic [WIDTH-1:0]         fifo_din,
   input  logic [WIDTH-1:0]         fifo_count,
   input  logic                     fifo_full,
   output state_t                   dbg_state
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   // Handshake: requester i's word is taken on a clk edge where req[i] & ack[i];
   // ack is combinational and only the current owner can see it high.

   state_t             r_state,     w_state_nxt;
   logic [NUM_REQ-1:0] r_grant,     w_grant_nxt;
   logic [IDX_W-1:0]   r_owner,     w_owner_nxt;
   logic [IDX_W-1:0]   r_rr_ptr,    w_rr_ptr_nxt;
   logic [CNT_W-1:0]   r_burst_cnt, w_burst_cnt_nxt;
   logic               r_fifo_we,   w_fifo_we_nxt;
   logic [WIDTH-1:0]   r_fifo_din,  w_fifo_din_nxt;

   logic [IDX_W-1:0]   w_pick;
   logic               w_pick_valid;
   logic [WIDTH:0]     w_sum;
   logic               w_space;
   logic               w_owner_req;
   logic [WIDTH-1:0]   w_owner_data;
   logic               w_accept;
   logic               w_last;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .i_req    (req),
      .i_rr_ptr (r_rr_ptr),
      .o_pick   (w_pick),
      .o_valid  (w_pick_valid)
   );

   // The word on fifo_we is not yet in fifo_count, so it occupies a slot here.
   assign w_sum        = {1'b0, fifo_count} + (WIDTH + 1)'(r_fifo_we);
   assign w_space      = !fifo_full && (w_sum < (WIDTH + 1)'(DEPTH));
   assign w_owner_req  = req[r_owner];
   assign w_owner_data = data[r_owner*WIDTH +: WIDTH];
   assign w_accept     = (r_state == ST_BURST) && w_owner_req && w_space;
   assign w_last       = (r_burst_cnt == CNT_W'(MAX_BURST - 1));

   assign ack       = ((r_state == ST_BURST) && w_space) ? (r_grant & req) : '0;
   assign grant     = r_grant;
   assign fifo_we   = r_fifo_we;
   assign fifo_din  = r_fifo_din;
   assign dbg_state = r_state;

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_owner_nxt     = r_owner;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_burst_cnt_nxt = r_burst_cnt;
      w_fifo_we_nxt   = 1'b0;
      w_fifo_din_nxt  = r_fifo_din;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) begin
               w_grant_nxt     = NUM_REQ'(onehot(3'(w_pick)));
               w_owner_nxt     = w_pick;
               w_burst_cnt_nxt = '0;
               w_state_nxt     = ST_BURST;
            end
         end
         ST_BURST: begin
            if (w_accept) begin
               w_fifo_we_nxt   = 1'b1;
               w_fifo_din_nxt  = w_owner_data;
               w_burst_cnt_nxt = r_burst_cnt + 1'b1;
            end
            if (!w_owner_req || (w_accept && w_last)) begin
               w_grant_nxt  = '0;
               w_rr_ptr_nxt = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
               w_state_nxt  = ST_IDLE;
            end
         end
         default: begin
            w_grant_nxt = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_grant     <= '0;
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
         r_fifo_we   <= 1'b0;
         r_fifo_din  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_owner     <= w_owner_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
         r_fifo_we   <= w_fifo_we_nxt;
         r_fifo_din  <= w_fifo_din_nxt;
      end
   end

endmodule

// File: tb/tb_simple_fifo_write_arbiter.sv
// Directed bench for simple_fifo_write_arbiter: expected words and grant order
// are queued up front and a negedge monitor compares them as the DUT emits them.
module tb_simple_fifo_write_arbiter;
   import simple_fifo_arb_pkg::*;

   localparam int NUM_REQ   = 4;
   localparam int WIDTH     = 8;
   localparam int DEPTH     = 8;
   localparam int MAX_BURST = 4;

   logic                     clk;
   logic                     reset;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] data;
   logic [NUM_REQ-1:0]       ack;
   logic [NUM_REQ-1:0]       grant;
   logic                     fifo_we;
   logic [WIDTH-1:0]         fifo_din;
   logic [WIDTH-1:0]         fifo_count;
   logic                     fifo_full;
   state_t                   dbg_state;

   simple_fifo_write_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .data       (data),
      .ack        (ack),
      .grant      (grant),
      .fifo_we    (fifo_we),
      .fifo_din   (fifo_din),
      .fifo_count (fifo_count),
      .fifo_full  (fifo_full),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0]   exp_q[$];
   logic [NUM_REQ-1:0] gnt_q[$];

   int                 left[NUM_REQ];
   logic [WIDTH-1:0]   nxt[NUM_REQ];
   logic [WIDTH-1:0]   step[NUM_REQ];
   logic [NUM_REQ-1:0] last_ack;
   int                 ack_cnt;
   logic [NUM_REQ-1:0] prev_grant;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // scoreboard monitor
   initial prev_grant = '0;
   always @(negedge clk) begin
      if (reset && fifo_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0h required=none", fifo_din);
         end else begin
            check("fifo_din", 32'(fifo_din), 32'(exp_q.pop_front()));
         end
      end
      if (reset && grant != '0 && prev_grant == '0) begin
         if (gnt_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_grant actual=%0h required=none", grant);
         end else begin
            check("grant_order", 32'(grant), 32'(gnt_q.pop_front()));
         end
      end
      prev_grant <= grant;
   end

   // driver tasks
   task automatic apply();
      for (int i = 0; i < NUM_REQ; i++) begin
         req[i] = (left[i] > 0);
         data[i*WIDTH +: WIDTH] = nxt[i];
      end
   endtask

   task automatic cycle();
      logic [NUM_REQ-1:0] acked;
      @(negedge clk);
      last_ack = ack;
      acked    = ack & req;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (acked[i]) begin
            left[i]--;
            nxt[i] = nxt[i] + step[i];
            ack_cnt++;
         end
      end
      apply();
   endtask

   function automatic bit all_done();
      for (int i = 0; i < NUM_REQ; i++) if (left[i] > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(all_done() && grant == '0 && !fifo_we) && n < 300) begin
         cycle();
         n++;
      end
      if (n >= 300) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=busy required=idle", name);
      end
   endtask

   int ord[4] = '{1, 2, 3, 0};

   initial begin
      reset      = 1'b0;
      fifo_count = '0;
      fifo_full  = 1'b0;
      ack_cnt    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         left[i] = 1;
         nxt[i]  = WIDTH'(8'hA0 + i);
         step[i] = 8'h01;
      end
      apply();

      // 1: reset with all requesters asking
      for (int i = 0; i < NUM_REQ; i++) begin
         exp_q.push_back(WIDTH'(8'hA0 + i));
         gnt_q.push_back(NUM_REQ'(1 << i));
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant", 32'(grant), 0);
      check("rst_ack", 32'(ack), 0);
      check("rst_we", 32'(fifo_we), 0);
      check("rst_din", 32'(fifo_din), 0);
      reset = 1'b1;
      cycle();
      check("first_grant", 32'(grant), 32'h1);
      cycle();
      check("first_we", 32'(fifo_we), 1);
      check("first_din", 32'(fifo_din), 32'hA0);
      wait_idle("t1");

      // 2: single requester, three words
      ack_cnt = 0;
      left[1] = 3; nxt[1] = 8'h11; step[1] = 8'h11;
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      gnt_q.push_back(4'b0010);
      apply();
      wait_idle("t2");
      check("t2_ack_cycles", 32'(ack_cnt), 3);
      left[0] = 1; nxt[0] = 8'h0A;
      left[2] = 1; nxt[2] = 8'h0C;
      gnt_q.push_back(4'b0100); gnt_q.push_back(4'b0001);
      exp_q.push_back(8'h0C); exp_q.push_back(8'h0A);
      apply();
      wait_idle("t2b");

      // 3: everyone streaming, forced rotation every MAX_BURST words
      for (int i = 0; i < NUM_REQ; i++) begin
         left[i] = 8;
         nxt[i]  = WIDTH'(i * 16);
         step[i] = 8'h01;
      end
      for (int r = 0; r < 2; r++) begin
         for (int j = 0; j < 4; j++) begin
            gnt_q.push_back(NUM_REQ'(1 << ord[j]));
            for (int k = 0; k < MAX_BURST; k++) exp_q.push_back(WIDTH'(ord[j] * 16 + r * 4 + k));
         end
      end
      apply();
      wait_idle("t3");

      // 4: nearly full FIFO, in-flight write counted
      fifo_count = 8'd6;
      left[2] = 5; nxt[2] = 8'h40;
      for (int k = 0; k < 5; k++) exp_q.push_back(WIDTH'(8'h40 + k));
      gnt_q.push_back(4'b0100); gnt_q.push_back(4'b0100);
      apply();
      cycle();
      check("t4_grant", 32'(grant), 32'h4);
      cycle();
      check("t4_ack1", 32'(last_ack), 32'h4);
      cycle();
      check("t4_ack2_inflight", 32'(last_ack), 32'h4);
      fifo_count = 8'd7;
      cycle();
      check("t4_ack_stall", 32'(last_ack), 0);
      fifo_count = 8'd8;
      cycle();
      check("t4_ack_full_count", 32'(last_ack), 0);
      check("t4_we_stall", 32'(fifo_we), 0);
      check("t4_grant_held", 32'(grant), 32'h4);
      fifo_count = 8'd6;
      wait_idle("t4");
      fifo_count = '0;

      // 5: fifo_full stall, owner gives up
      left[3] = 3; nxt[3] = 8'h50;
      exp_q.push_back(8'h50);
      gnt_q.push_back(4'b1000);
      apply();
      cycle();
      cycle();
      fifo_full = 1'b1;
      cycle();
      check("t5_ack_full", 32'(last_ack), 0);
      check("t5_grant_held", 32'(grant), 32'h8);
      check("t5_we_stall", 32'(fifo_we), 0);
      left[3] = 0;
      apply();
      cycle();
      check("t5_release", 32'(grant), 0);
      check("t5_no_write", 32'(fifo_we), 0);
      fifo_full = 1'b0;
      left[0] = 1; nxt[0] = 8'h60;
      left[3] = 1;
      gnt_q.push_back(4'b0001); gnt_q.push_back(4'b1000);
      exp_q.push_back(8'h60); exp_q.push_back(8'h51);
      apply();
      wait_idle("t5");

      // 6: asynchronous reset mid-burst
      left[1] = 4; nxt[1] = 8'h70; step[1] = 8'h01;
      gnt_q.push_back(4'b0010);
      exp_q.push_back(8'h70); exp_q.push_back(8'h71);
      apply();
      cycle();
      cycle();
      cycle();
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("t6_async_grant", 32'(grant), 0);
      check("t6_async_we", 32'(fifo_we), 0);
      check("t6_async_ack", 32'(ack), 0);
      left[0] = 1; nxt[0] = 8'h80;
      gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010);
      exp_q.push_back(8'h80); exp_q.push_back(8'h72); exp_q.push_back(8'h73);
      apply();
      @(posedge clk);
      #1;
      reset = 1'b1;
      wait_idle("t6");

      repeat (2) @(posedge clk);
      check("words_drained", 32'(exp_q.size()), 0);
      check("grants_drained", 32'(gnt_q.size()), 0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
